button_event_scanner: RTL and testbench

Time-shared debounce controller for NUM_BTN raw button/switch inputs on the PS/2-to-68k board. A shared prescaler generates a sample tick. A scan state machine then visits one channel per clock and updates that channel's stability counter. Each confirmed press or release becomes an event {id, press} in a small FIFO, drained by the host-side logic over a valid/ready handshake.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_event_scanner_if.sv | 21 ++
 rtl/button_event_scanner_event_fifo.sv | 93 +++++++++
 rtl/button_event_scanner.sv | 183 ++++++++++++++++++
 tb/tb_button_event_scanner.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and constants for the button event scanner: scan FSM state,
// the event record that travels through the queue, and field widths.
// -----------------------------------------------------------------------------
package button_pkg;

  // Width of one queued event: 3-bit channel id + 1-bit press flag.
  localparam int EVT_W = 4;

  // Per-channel stability counter width.
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [2:0] id;     // channel index
    logic       press;  // 1 = press (0->1), 0 = release (1->0)
  } evt_t;

endpackage

// File: rtl/button_event_scanner_if.sv
// -----------------------------------------------------------------------------
// button_event_scanner_if
// Valid/ready event stream from the scanner to the host-side consumer.
//   evt_valid : queue head holds an event
//   evt_id    : channel index of the head event
//   evt_press : 1 = press, 0 = release
//   evt_ready : consumer accepts the head event this clock
// master = scanner (producer), slave = consumer.
// -----------------------------------------------------------------------------
interface button_event_scanner_if;
  import button_pkg::*;

  logic             evt_valid;
  logic [EVT_W-2:0] evt_id;
  logic             evt_press;
  logic             evt_ready;

  modport master (output evt_valid, output evt_id, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_press, output evt_ready);

endinterface

// File: rtl/button_event_scanner_event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous FIFO with a registered head. A push into an empty queue shows up
// on o_head/o_valid on the following clock. A push while full is accepted only
// if a pop happens in the same clock; otherwise the caller sees o_full and
// decides what to do with the rejected entry.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_push       : write request, i_push_data : entry to write
//   o_full       : queue holds DEPTH entries
//   i_pop        : consume head (ignored when empty)
//   o_empty      : queue holds no entries
//   o_valid      : head register holds a live entry (== !o_empty)
//   o_head       : head entry, stable until popped
// -----------------------------------------------------------------------------
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same clock frees the slot, so a full queue can still accept.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop_ok);
    w_count_nxt  = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    w_head_nxt   = '0;
    if (w_count_nxt != '0) begin
      // When the next head slot is the one being written right now, the
      // memory does not hold it yet: forward the incoming data.
      if (w_push_ok && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = i_push_data;
      else                                         w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are live, so resetting the array would only cost logic.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/button_event_scanner.sv
// -----------------------------------------------------------------------------
// button_event_scanner
// Time-shared debouncer for NUM_BTN raw button inputs. A prescaler produces a
// sample tick every TICK_DIV clocks; on each tick a scan FSM visits one channel
// per clock and updates that channel's stability counter. A level that differs
// from the debounced state on STABLE_CNT consecutive ticks is accepted and
// reported as an {id, press} event through a small queue.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   btn_raw     : asynchronous raw levels, 1 = pressed
//   btn_state   : debounced levels
//   evt         : event stream (master side of button_event_scanner_if)
//   overflow    : sticky, at least one event was dropped on a full queue
//   ovf_clr     : clears overflow (a same-clock drop keeps it set)
// -----------------------------------------------------------------------------
module button_event_scanner
  import button_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int TICK_DIV   = 16,
  parameter int STABLE_CNT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BTN-1:0]           btn_raw,
  output logic [NUM_BTN-1:0]           btn_state,
  button_event_scanner_if.master       evt,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CH_W = (NUM_BTN > 1)  ? $clog2(NUM_BTN)  : 1;

  // Two-flop synchronizers for the asynchronous inputs.
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  logic [PW-1:0]      r_presc;
  logic               w_tick;

  scan_state_t        r_state, w_state_nxt;
  logic [CH_W-1:0]    r_ch, w_ch_nxt;
  logic               w_scan;

  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_btn_state;
  logic               r_overflow;

  logic               w_differ;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_accept;
  evt_t               w_evt;
  evt_t               w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

  // ---------------------------------------------------------------- sync ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ----------------------------------------------------------- prescaler ----
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // ------------------------------------------------------------ scan FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_nxt = SCAN;
          w_ch_nxt    = '0;
        end
      end
      SCAN: begin
        if (r_ch == CH_W'(NUM_BTN - 1)) begin
          w_state_nxt = IDLE;
          w_ch_nxt    = '0;
        end else begin
          w_ch_nxt    = r_ch + CH_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ch_nxt    = '0;
      end
    endcase
  end

  assign w_scan = (r_state == SCAN);

  // -------------------------------------------------- channel processing ----
  assign w_differ  = (r_sync2[r_ch] != r_btn_state[r_ch]);
  assign w_cnt_inc = r_cnt[r_ch] + CNT_W'(1);
  // The STABLE_CNT-th consecutive differing sample accepts the new level.
  assign w_accept  = w_scan && w_differ && (w_cnt_inc >= CNT_W'(STABLE_CNT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) r_cnt[i] <= '0;
      r_btn_state <= '0;
    end else if (w_scan) begin
      if (!w_differ) begin
        // One agreeing sample restarts the stability window.
        r_cnt[r_ch] <= '0;
      end else if (w_accept) begin
        r_cnt[r_ch]       <= '0;
        r_btn_state[r_ch] <= r_sync2[r_ch];
      end else begin
        r_cnt[r_ch] <= w_cnt_inc;
      end
    end
  end

  assign btn_state = r_btn_state;

  // --------------------------------------------------------- event queue ----
  always_comb begin
    w_evt       = '0;
    w_evt.id    = 3'(r_ch);
    w_evt.press = r_sync2[r_ch];
  end

  assign w_pop  = evt.evt_ready && !w_empty;
  // btn_state still updates on a drop; only the event is lost.
  assign w_drop = w_accept && w_full && !w_pop;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_event_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_accept),
    .i_push_data (w_evt),
    .o_full      (w_full),
    .i_pop       (w_pop),
    .o_empty     (w_empty),
    .o_valid     (evt.evt_valid),
    .o_head      (w_head)
  );

  assign evt.evt_id    = w_head.id;
  assign evt.evt_press = w_head.press;

  // ------------------------------------------------------------ overflow ----
  // A drop takes priority over a clear in the same clock.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_button_event_scanner.sv
// -----------------------------------------------------------------------------
// tb_button_event_scanner
// Directed bench for button_event_scanner with default parameters
// (NUM_BTN=4, TICK_DIV=16, STABLE_CNT=8, FIFO_DEPTH=4). Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_button_event_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_state;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  button_event_scanner_if evt_if ();

  button_event_scanner #(
    .NUM_BTN    (4),
    .TICK_DIV   (16),
    .STABLE_CNT (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .evt       (evt_if),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) until btn_state[ch] == val; n returns elapsed clocks.
  task automatic wait_btn(input int ch, input logic val, input int maxc, output int n);
    n = 0;
    while (btn_state[ch] !== val && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Waits (bounded) for an event, compares it, then pops it with a one-clock ready.
  task automatic expect_evt(input string tag, input int id, input logic press);
    int n = 0;
    while (evt_if.evt_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
    check({tag, "_id"},    32'(evt_if.evt_id),    32'(id));
    check({tag, "_press"}, 32'(evt_if.evt_press), 32'(press));
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    int n;
    int vseen;
    int hiseen;

    evt_if.evt_ready = 1'b0;

    // ---- reset state
    rst_n = 1'b0;
    clks(2);
    check("rst_btn_state", 32'(btn_state),         32'd0);
    check("rst_evt_valid", 32'(evt_if.evt_valid),  32'd0);
    check("rst_evt_id",    32'(evt_if.evt_id),     32'd0);
    check("rst_evt_press", 32'(evt_if.evt_press),  32'd0);
    check("rst_overflow",  32'(overflow),          32'd0);
    rst_n = 1'b1;

    // ---- 1: quiet inputs produce nothing
    vseen = 0;
    repeat (500) begin
      @(negedge clk);
      if (evt_if.evt_valid) vseen++;
    end
    check("t1_no_events", 32'(vseen),     32'd0);
    check("t1_btn_state", 32'(btn_state), 32'd0);
    check("t1_overflow",  32'(overflow),  32'd0);

    // ---- 2: single press and release on channel 2
    btn_raw[2] = 1'b1;
    wait_btn(2, 1'b1, 200, n);
    check("t2_rise_within_148", 32'(n <= 148), 32'd1);
    check("t2_btn_state",       32'(btn_state), 32'b0100);
    expect_evt("t2_press", 2, 1'b1);
    clks(2);
    check("t2_single_event", 32'(evt_if.evt_valid), 32'd0);
    btn_raw[2] = 1'b0;
    wait_btn(2, 1'b0, 200, n);
    check("t2_fall", 32'(btn_state), 32'b0000);
    expect_evt("t2_release", 2, 1'b0);

    // ---- 3: bounce on channel 1 is rejected, then a steady press is accepted
    vseen  = 0;
    hiseen = 0;
    for (int i = 0; i < 25; i++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (40) begin
        @(negedge clk);
        if (evt_if.evt_valid) vseen++;
        if (btn_state[1])     hiseen++;
      end
    end
    check("t3_bounce_no_event", 32'(vseen),  32'd0);
    check("t3_bounce_state_lo", 32'(hiseen), 32'd0);
    btn_raw[1] = 1'b1;
    wait_btn(1, 1'b1, 200, n);
    check("t3_hold_state", 32'(btn_state), 32'b0010);
    expect_evt("t3_press", 1, 1'b1);
    clks(2);
    check("t3_single_event", 32'(evt_if.evt_valid), 32'd0);
    btn_raw[1] = 1'b0;
    wait_btn(1, 1'b0, 200, n);
    expect_evt("t3_release", 1, 1'b0);

    // ---- 4: six events with no consumer -> four kept, overflow set
    for (int k = 0; k < 6; k++) begin
      btn_raw[0] = (k % 2 == 0);
      clks(200);
      if (k == 3) check("t4_no_ovf_at_4", 32'(overflow), 32'd0);
      if (k == 4) begin
        check("t4_ovf_at_5",        32'(overflow),     32'd1);
        check("t4_state_on_drop",   32'(btn_state[0]), 32'd1);
      end
    end
    check("t4_state_final", 32'(btn_state[0]), 32'd0);
    expect_evt("t4_e0", 0, 1'b1);
    expect_evt("t4_e1", 0, 1'b0);
    expect_evt("t4_e2", 0, 1'b1);
    expect_evt("t4_e3", 0, 1'b0);
    clks(2);
    check("t4_drained",       32'(evt_if.evt_valid), 32'd0);
    check("t4_ovf_sticky",    32'(overflow),         32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_cleared",   32'(overflow),         32'd0);

    // ---- 5: push and pop in the same clock on a full queue
    // All four channels press together: pushes on edges T..T+3 fill the queue.
    btn_raw = 4'b1111;
    wait_btn(0, 1'b1, 200, n);
    check("t5_group_press", 32'(n < 200), 32'd1);
    // Released right after edge T: channel 0 accepts exactly at T+128 and
    // channel 1 at T+129 (8 ticks of 16 clocks later).
    btn_raw[0] = 1'b0;
    btn_raw[1] = 1'b0;
    clks(127);
    check("t5_pre_release_state", 32'(btn_state[0]),     32'd1);
    check("t5_full_valid",        32'(evt_if.evt_valid), 32'd1);
    evt_if.evt_ready = 1'b1;
    clks(1);
    check("t5_release0_at_T128",  32'(btn_state[0]), 32'd0);
    clks(1);
    evt_if.evt_ready = 1'b0;
    check("t5_release1_at_T129",  32'(btn_state[1]), 32'd0);
    check("t5_no_overflow",       32'(overflow),     32'd0);
    expect_evt("t5_e0", 2, 1'b1);
    expect_evt("t5_e1", 3, 1'b1);
    expect_evt("t5_e2", 0, 1'b0);
    expect_evt("t5_e3", 1, 1'b0);
    clks(2);
    check("t5_drained", 32'(evt_if.evt_valid), 32'd0);

    // Return channels 2/3 to released.
    btn_raw = 4'b0000;
    wait_btn(3, 1'b0, 200, n);
    expect_evt("t5_r2", 2, 1'b0);
    expect_evt("t5_r3", 3, 1'b0);

    // ---- 6: reset during SCAN with a pending event and a partial count
    btn_raw[3] = 1'b1;
    clks(60);
    btn_raw[2] = 1'b1;                       // channel 2 starts counting
    wait_btn(3, 1'b1, 200, n);               // edge T3: channel 3 accepted
    check("t6_pending_press3", 32'(n < 200), 32'd1);
    // Channel 0 is processed at T3+13, so the cycle before T3+14 is in SCAN.
    clks(13);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
    check("t6_rst_btn_state", 32'(btn_state),        32'd0);
    check("t6_rst_evt_id",    32'(evt_if.evt_id),    32'd0);
    check("t6_rst_overflow",  32'(overflow),         32'd0);
    // Fresh counters need 8 full ticks (~129 clocks) before anything accepts.
    clks(100);
    check("t6_restart_state", 32'(btn_state),        32'd0);
    check("t6_restart_valid", 32'(evt_if.evt_valid), 32'd0);
    expect_evt("t6_p2", 2, 1'b1);
    expect_evt("t6_p3", 3, 1'b1);
    check("t6_final_state", 32'(btn_state), 32'b1100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
